uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares the SoC's single byte-wide UART transmitter (tx_send/tx_data strobe interface) between NUM_REQ independent requesters, such as the CPU debug port and a hardware trace source. Requesters are served round-robin. By default, ownership is held until a newline byte so that text lines from different sources never interleave on the console. The block sits between the requesters and the uart_tx instance inside soc.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
LOCK_ON_NEWLINE, 1, 1 = hold the grant until 0x0A is sent; 0 = re-arbitrate after every byte
MAX_HOLD_CYCLES, 1024, idle cycles a locked owner may leave the transmitter unused before forced release (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_ready  out  NUM_REQ  one-cycle accept pulse; byte is taken when valid&ready
tx_send  out  1  one-cycle strobe to the UART transmitter
tx_data  out  8  byte to the UART; stable from tx_send until the next accept
tx_busy  in  1  UART busy; rises the cycle after tx_send, stays high until the frame is done
owner  out  clog2(NUM_REQ) (min 1)  current/last granted requester index
locked  out  1  high while an owner holds the line (states SEND, DRAIN, HOLD)

Behaviour:
- Reset (one clk edge with reset=1) produces these values:
  - state=IDLE; tx_send=0, tx_data=0, req_ready=0, owner=0, locked=0.
  - The internal round-robin pointer last=NUM_REQ-1, so requester 0 has priority first.
  - The hold counter is 0.
- Reset asserted mid-frame aborts the sequence immediately. Pending bytes are dropped; no tx_send is issued after reset.
- State IDLE:
  - If any req_valid is high, grant the first set bit searching last+1, last+2, ... (mod NUM_REQ).
  - The same cycle, assert req_ready[g] combinationally and register the byte into tx_data. Set owner=g and go to SEND.
  - If no req_valid is high, stay in IDLE.
- State SEND:
  - If tx_busy=0, pulse tx_send for exactly one cycle and go to DRAIN. Otherwise wait in SEND.
  - Latency: byte accepted at cycle N gives tx_send at N+1 when the UART is idle.
- State DRAIN:
  - tx_busy is ignored in the first DRAIN cycle, which covers the UART's one-cycle busy rise delay.
  - From the second cycle onward, when tx_busy=0, apply the release decision.
  - Release when LOCK_ON_NEWLINE=0, or when the byte just sent is 0x0A. On release: last=owner, go to IDLE.
  - Otherwise clear the hold counter and go to HOLD.
- State HOLD:
  - Only the owner is eligible; all other req_ready stay at 0.
  - If req_valid[owner]=1: pulse req_ready[owner], register the byte, go to SEND.
  - Otherwise increment the hold counter. When it reaches MAX_HOLD_CYCLES, release (last=owner, go to IDLE).
  - If the owner's valid arrives in the same cycle the counter reaches the limit, the byte is accepted and there is no release.
- req_ready is never asserted for more than one requester, and never in SEND or DRAIN.
- A requester may deassert valid without being accepted; the arbiter holds no state for it.
- owner keeps its last value in IDLE. locked=0 in IDLE.
- Round-robin: after a release, the released owner has the lowest priority in the next arbitration. No requester waits more than NUM_REQ-1 grant periods.
- tx_data is never 'x': it holds the last sent byte after a send.

Test Plan:
- Reset, then req 0 sends "A\n" (0x41, 0x0A), UART idle → tx_send at accept+1, two sends, then IDLE, locked=0, owner=0.
- Req 0 and req 1 both valid from reset → req 0 granted first. Req 0 streams "hi\n" while req 1 waits with 0x58 held. 0x58 is sent only after 0x0A, and no 0x58 appears between 'h' and 'i'.
- LOCK_ON_NEWLINE=0, both requesters continuously valid with 0x31/0x32 → output alternates 0x31, 0x32, 0x31, ...
- MAX_HOLD_CYCLES=8, req 0 sends 0x41 then drops valid, req 1 valid with 0x42 → 0x42 is accepted after exactly 8 HOLD cycles.
- tx_busy forced high for 20 cycles after a send → no second tx_send until busy falls, and req_ready stays 0 throughout.
- reset pulsed while in DRAIN with req valid → all outputs return to reset values, and the next grant goes to req 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one byte-wide UART transmitter among NUM_REQ requesters.
// Ownership can be held until a newline so that console lines from different sources never interleave.
module uart_tx_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter bit LOCK_ON_NEWLINE = 1'b1,
    parameter int MAX_HOLD_CYCLES = 1024,
    localparam int OW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_send,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [OW-1:0]        owner,
    output logic                 locked
);

    localparam int HCW = $clog2(MAX_HOLD_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SEND, DRAIN, HOLD} state_t;

    state_t         state, state_n;
    logic [OW-1:0]  last, last_n;
    logic [OW-1:0]  owner_n;
    logic [7:0]     data_n;
    logic [HCW-1:0] hold_cnt, hold_n;
    logic           drain_first, first_n;
    logic           grant_any;
    logic [OW-1:0]  grant;

    // Search starts just after the last released owner, so it gets lowest priority.
    always_comb begin
        int idx;
        grant_any = 1'b0;
        grant     = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant     = OW'(idx);
            end
        end
    end

    always_comb begin
        state_n   = state;
        last_n    = last;
        owner_n   = owner;
        data_n    = tx_data;
        hold_n    = hold_cnt;
        first_n   = 1'b0;
        req_ready = '0;
        tx_send   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    req_ready[grant] = 1'b1;
                    data_n           = req_data[8*int'(grant) +: 8];
                    owner_n          = grant;
                    state_n          = SEND;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_send = 1'b1;
                    first_n = 1'b1;
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                // The UART raises busy one cycle late, so the first DRAIN cycle cannot trust it.
                if (!drain_first && !tx_busy) begin
                    if (!LOCK_ON_NEWLINE || tx_data == 8'h0A) begin
                        last_n  = owner;
                        state_n = IDLE;
                    end else begin
                        hold_n  = '0;
                        state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                if (req_valid[owner]) begin
                    req_ready[owner] = 1'b1;
                    data_n           = req_data[8*int'(owner) +: 8];
                    state_n          = SEND;
                end else begin
                    hold_n = hold_cnt + HCW'(1);
                    if (int'(hold_cnt) + 1 >= MAX_HOLD_CYCLES) begin
                        last_n  = owner;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last        <= OW'(NUM_REQ - 1);
            owner       <= '0;
            tx_data     <= '0;
            hold_cnt    <= '0;
            drain_first <= 1'b0;
        end else begin
            state       <= state_n;
            last        <= last_n;
            owner       <= owner_n;
            tx_data     <= data_n;
            hold_cnt    <= hold_n;
            drain_first <= first_n;
        end
    end

    assign locked = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester scoreboard queues, line-lock model and randomized line traffic.
// A second instance with LOCK_ON_NEWLINE=0 checks per-byte alternation.
module tb_uart_tx_arbiter;
    localparam int NA = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NA-1:0]   a_valid = '0;
    logic [8*NA-1:0] a_data = '0;
    logic [NA-1:0]   a_ready;
    logic            a_send;
    logic [7:0]      a_tx;
    logic            a_busy = 1'b0;
    logic            force_busy = 1'b0;
    logic            a_busy_w;
    logic [1:0]      a_owner;
    logic            a_locked;
    int              bcnt = 0;
    int              frame_len = 3;

    logic [1:0]  b_valid = '0;
    logic [15:0] b_data = '0;
    logic [1:0]  b_ready;
    logic        b_send;
    logic [7:0]  b_tx;
    logic        b_busy = 1'b0;
    logic        b_owner;
    logic        b_locked;

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] exp_q[NA][$];
    logic [7:0] log_q[$];
    bit  lock_chk = 1'b0;
    bit  line_open = 1'b0;
    int  line_owner = 0;

    assign a_busy_w = a_busy | force_busy;

    uart_tx_arbiter #(.NUM_REQ(NA), .LOCK_ON_NEWLINE(1'b1), .MAX_HOLD_CYCLES(8)) dut_a (
        .clk(clk), .reset(reset), .req_valid(a_valid), .req_data(a_data), .req_ready(a_ready),
        .tx_send(a_send), .tx_data(a_tx), .tx_busy(a_busy_w), .owner(a_owner), .locked(a_locked));

    uart_tx_arbiter #(.NUM_REQ(2), .LOCK_ON_NEWLINE(1'b0), .MAX_HOLD_CYCLES(8)) dut_b (
        .clk(clk), .reset(reset), .req_valid(b_valid), .req_data(b_data), .req_ready(b_ready),
        .tx_send(b_send), .tx_data(b_tx), .tx_busy(b_busy), .owner(b_owner), .locked(b_locked));

    always #5 clk = ~clk;

    // UART model: busy rises the cycle after tx_send and stays high for frame_len cycles.
    always @(posedge clk) begin
        if (reset) begin
            a_busy <= 1'b0;
            bcnt   <= 0;
        end else if (a_send) begin
            a_busy <= 1'b1;
            bcnt   <= frame_len;
        end else if (bcnt > 1) begin
            bcnt <= bcnt - 1;
        end else begin
            a_busy <= 1'b0;
            bcnt   <= 0;
        end
        b_busy <= reset ? 1'b0 : b_send;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every byte sent must be the next one its requester issued; open lines must not interleave.
    always @(negedge clk) begin
        int o;
        logic [7:0] e;
        if (a_send) begin
            o = int'(a_owner);
            chk("send_locked", 32'(a_locked), 32'd1);
            if (o >= NA || exp_q[o].size() == 0) begin
                chk("send_unexpected_owner", 32'(o), 32'hFFFF);
            end else begin
                e = exp_q[o].pop_front();
                chk("send_data", 32'(a_tx), 32'(e));
            end
            if (lock_chk && line_open) chk("line_interleave_owner", 32'(o), 32'(line_owner));
            line_open  = (a_tx != 8'h0A);
            line_owner = o;
            log_q.push_back(a_tx);
        end
        if (|a_ready) begin
            chk("ready_onehot", 32'($onehot(a_ready)), 32'd1);
            chk("ready_without_valid", 32'(a_ready & ~a_valid), 32'd0);
        end
        if (reset || !lock_chk) line_open = 1'b0;
    end

    task automatic present(input int i, input logic [7:0] b);
        a_valid[i]       = 1'b1;
        a_data[8*i +: 8] = b;
        exp_q[i].push_back(b);
    endtask

    task automatic wait_acc(input int i);
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (a_valid[i] && a_ready[i]) break;
        end
        if (k == 400) chk("accept_timeout", 32'(i), 32'hFFFF);
        else chk("accept_grant", 32'(a_ready), 32'd1 << i);
        @(posedge clk); #1;
        a_valid[i] = 1'b0;
    endtask

    task automatic put(input int i, input logic [7:0] b);
        present(i, b);
        wait_acc(i);
    endtask

    task automatic idle_wait(input string name);
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (!a_locked) break;
        end
        chk({name, "_idle"}, 32'(a_locked), 32'd0);
        for (int i = 0; i < NA; i++) chk({name, "_queue_empty"}, 32'(exp_q[i].size()), 32'd0);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        a_valid = '0;
        b_valid = '0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic run_random(input int ncyc);
        int left[NA];
        int gap[NA];
        bit acc[NA];
        bit act;
        int c;
        for (int i = 0; i < NA; i++) begin
            left[i] = 0;
            gap[i]  = $urandom_range(0, 4);
        end
        c = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NA; i++) acc[i] = a_valid[i] && a_ready[i];
            @(posedge clk); #1;
            c++;
            frame_len = $urandom_range(1, 5);
            act = 1'b0;
            for (int i = 0; i < NA; i++) begin
                if (acc[i]) begin
                    a_valid[i] = 1'b0;
                    // Short in-line gaps keep owners well inside the hold window.
                    gap[i] = (left[i] > 0) ? $urandom_range(0, 2) : $urandom_range(0, 12);
                end else if (!a_valid[i]) begin
                    if (gap[i] > 0) gap[i]--;
                    else if (left[i] > 0 || c < ncyc) begin
                        if (left[i] == 0) left[i] = $urandom_range(1, 5);
                        left[i]--;
                        present(i, (left[i] == 0) ? 8'h0A : 8'h41 + 8'($urandom_range(0, 25)));
                    end
                end
                if (left[i] > 0 || a_valid[i]) act = 1'b1;
            end
            if (c >= ncyc && !act) break;
            if (c >= ncyc + 3000) begin
                chk("random_drain_timeout", 32'(c), 32'(ncyc));
                break;
            end
        end
    endtask

    initial begin
        int k;
        logic [7:0] seq[4];

        // Reset state.
        do_reset();
        @(negedge clk);
        chk("rst_tx_send", 32'(a_send), 32'd0);
        chk("rst_tx_data", 32'(a_tx), 32'd0);
        chk("rst_ready", 32'(a_ready), 32'd0);
        chk("rst_owner", 32'(a_owner), 32'd0);
        chk("rst_locked", 32'(a_locked), 32'd0);

        // "A\n" from req 0 with an idle UART.
        @(posedge clk); #1;
        log_q.delete();
        put(0, 8'h41);
        @(negedge clk);
        chk("t1_send_latency", 32'(a_send), 32'd1);
        @(posedge clk); #1;
        put(0, 8'h0A);
        idle_wait("t1");
        chk("t1_owner", 32'(a_owner), 32'd0);
        chk("t1_send_count", 32'(log_q.size()), 32'd2);

        // Req 1 waits behind a locked line from req 0.
        do_reset();
        log_q.delete();
        lock_chk = 1'b1;
        present(1, 8'h58);
        put(0, 8'h68);
        put(0, 8'h69);
        put(0, 8'h0A);
        wait_acc(1);
        idle_wait("t2");
        lock_chk = 1'b0;
        seq = '{8'h68, 8'h69, 8'h0A, 8'h58};
        chk("t2_send_count", 32'(log_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) chk("t2_order", 32'(log_q[i]), 32'(seq[i]));

        // Hold timeout: owner 0 goes silent after 0x41, req 1 gets in after 8 HOLD cycles.
        do_reset();
        frame_len = 3;
        put(0, 8'h41);
        present(1, 8'h42);
        @(negedge clk);
        chk("t4_send", 32'(a_send), 32'd1);
        for (k = 1; k < 100; k++) begin
            @(negedge clk);
            if (a_ready[1]) break;
        end
        // DRAIN covers the frame_len busy cycles plus one, then 8 HOLD cycles, then IDLE grants.
        chk("t4_hold_release_cycles", 32'(k), 32'(frame_len + 10));
        @(posedge clk); #1;
        a_valid[1] = 1'b0;
        idle_wait("t4");

        // UART busy stuck high for 20 cycles after a send.
        do_reset();
        put(0, 8'h41);
        @(negedge clk);
        chk("t5_send", 32'(a_send), 32'd1);
        @(posedge clk); #1;
        force_busy = 1'b1;
        present(0, 8'h0A);
        present(1, 8'h42);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t5_busy_ready", 32'(a_ready), 32'd0);
            chk("t5_busy_send", 32'(a_send), 32'd0);
        end
        @(posedge clk); #1;
        force_busy = 1'b0;
        wait_acc(0);
        wait_acc(1);
        idle_wait("t5");

        // Reset pulsed in DRAIN.
        do_reset();
        put(0, 8'h41);
        @(negedge clk);
        chk("t6_send", 32'(a_send), 32'd1);
        @(posedge clk); #1;
        do_reset();
        @(negedge clk);
        chk("t6_rst_tx_send", 32'(a_send), 32'd0);
        chk("t6_rst_tx_data", 32'(a_tx), 32'd0);
        chk("t6_rst_ready", 32'(a_ready), 32'd0);
        chk("t6_rst_owner", 32'(a_owner), 32'd0);
        chk("t6_rst_locked", 32'(a_locked), 32'd0);
        @(posedge clk); #1;
        present(1, 8'h42);
        present(0, 8'h0A);
        wait_acc(0);
        wait_acc(1);
        idle_wait("t6");

        // Per-byte re-arbitration alternates between two always-valid requesters.
        do_reset();
        log_q.delete();
        b_valid = 2'b11;
        b_data  = {8'h32, 8'h31};
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (|b_ready) chk("b_ready_onehot", 32'($onehot(b_ready)), 32'd1);
            if (b_send) begin
                chk("b_alt_data", 32'(b_tx), (k % 2 == 0) ? 32'h31 : 32'h32);
                chk("b_alt_owner", 32'(b_owner), 32'(k % 2));
                chk("b_locked", 32'(b_locked), 32'd1);
                k++;
            end
        end
        chk("b_send_count_min", 32'(k >= 6), 32'd1);
        b_valid = '0;

        // Randomized line traffic on three requesters.
        do_reset();
        lock_chk = 1'b1;
        run_random(3000);
        idle_wait("rand");
        lock_chk = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks done", n_chk);
        $fatal(1, "watchdog");
    end

endmodule
